fib_gen: RTL and testbench

Sequence generator that drives the write port of the 64-entry register file in lab03. On `start` it computes a Fibonacci-style sequence seeded with the register file's reset contents (entries 0 and 1 = 2). It writes one term per cycle into entries 2..63, then pulses `done`. The block sits directly upstream of the register file; its write outputs connect straight to that block's `wAddr`/`wDin`/`wEna`.

---
 rtl/fib_pkg.sv | 17 +
 rtl/fib_gen_if.sv | 17 +
 rtl/fib_add.sv | 31 +++
 rtl/fib_gen.sv | 125 ++++++++++++
 tb/tb_fib_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared defaults, FSM state type and constants for the Fibonacci register-file filler.
// Optional saturation mode is selected with the FIB_SAT_EN macro.
package fib_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 6;

  // Entries 0 and 1 hold the seeds; generation starts at entry 2.
  localparam int unsigned FIRST_ADDR = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_gen_if.sv
// Register-file write port: address, data and enable.
// The generator drives the master side and the register file consumes the slave side.
interface fib_gen_if
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wDin;
  logic              wEna;

  modport master (output wAddr, output wDin, output wEna);
  modport slave  (input  wAddr, input  wDin, input  wEna);

endinterface

// File: rtl/fib_add.sv
// Combinational term adder producing the sum and its carry-out.
// With FIB_SAT_EN defined it also provides the value clamped to all-ones on carry.
module fib_add
  import fib_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
`ifdef FIB_SAT_EN
  output logic [DATA_W-1:0] sat,
`endif
  output logic              carry
);

  logic [DATA_W:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    sum   = full[DATA_W-1:0];
    carry = full[DATA_W];
  end

`ifdef FIB_SAT_EN
  always_comb begin
    sat = carry ? '1 : full[DATA_W-1:0];
  end
`endif

endmodule

// File: rtl/fib_gen.sv
// Fibonacci-style sequence generator that fills register-file entries 2..2^ADDR_W-1.
// Define FIB_SAT_EN to clamp terms to all-ones on overflow instead of wrapping.
module fib_gen
  import fib_pkg::*;
#(
  parameter int unsigned       DATA_W = DEF_DATA_W,
  parameter int unsigned       ADDR_W = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] SEED0  = 32'h2,
  parameter logic [DATA_W-1:0] SEED1  = 32'h2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  fib_gen_if.master  wr,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  state_t            state;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ADDR_W-1:0] addr;

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_din;
  logic              w_ena;

  logic [DATA_W-1:0] sum;
  logic              carry;
  logic [DATA_W-1:0] term;

`ifdef FIB_SAT_EN
  logic [DATA_W-1:0] sat;

  fib_add #(.DATA_W(DATA_W)) u_add (
    .a     (a),
    .b     (b),
    .sum   (sum),
    .sat   (sat),
    .carry (carry)
  );

  // The clamped value is both written out and fed back, so later terms stay all-ones.
  always_comb begin
    term = carry ? sat : sum;
  end
`else
  fib_add #(.DATA_W(DATA_W)) u_add (
    .a     (a),
    .b     (b),
    .sum   (sum),
    .carry (carry)
  );

  always_comb begin
    term = sum;
  end
`endif

  localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      addr   <= '0;
      w_addr <= '0;
      w_din  <= '0;
      w_ena  <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          w_ena <= 1'b0;
          if (start) begin
            a     <= SEED0;
            b     <= SEED1;
            addr  <= START_ADDR;
            ovf   <= 1'b0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stall) begin
            w_ena <= 1'b0;
          end else begin
            w_ena  <= 1'b1;
            w_addr <= addr;
            w_din  <= term;
            a      <= b;
            b      <= term;
            addr   <= addr + 1'b1;
            if (carry) begin
              ovf <= 1'b1;
            end
            if (addr == LAST_ADDR) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_ena <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          w_ena <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr.wAddr = w_addr;
  assign wr.wDin  = w_din;
  assign wr.wEna  = w_ena;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_fib_gen.sv
// Directed self-checking bench for fib_gen: reset, plain run, stall, overflow, restart and abort.
// Expected terms follow FIB_SAT_EN in the same way as the design build.
module tb_fib_gen;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;

  logic clk;
  logic rst_n;
  logic start;
  logic stall;
  logic busy;
  logic done;
  logic ovf;

  int tests;
  int fails;

  fib_gen_if #(.DATA_W(DW), .ADDR_W(AW)) wr ();

  fib_gen #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .SEED0  (32'h2),
    .SEED1  (32'h2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stall (stall),
    .wr    (wr),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // Caller has just seen the start-accepting edge. Follows the run with a reference model.
  task automatic run(input int stall_at, input int stall_n, input int restart_at, input int abort_at);
    logic [31:0] ma, mb, term;
    logic [32:0] s;
    logic        movf;
    int          exp_addr, c, writes, stall_left, done_cyc;
    bit          seen, aborted;
    ma = 32'd2; mb = 32'd2; movf = 1'b0; exp_addr = 2;
    c = 0; writes = 0; stall_left = 0; done_cyc = -1; seen = 0; aborted = 0;
    for (int i = 0; i < 150 && !seen && !aborted; i++) begin
      step();
      c++;
      if (start) start = 1'b0;
      if (c == restart_at) start = 1'b1;
      if (stall_left > 0) begin
        check("stall_wena", {63'd0, wr.wEna}, 64'd0);
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end else if (wr.wEna) begin
        s = {1'b0, ma} + {1'b0, mb};
        term = s[31:0];
`ifdef FIB_SAT_EN
        if (s[32]) term = 32'hFFFF_FFFF;
`endif
        if (s[32]) movf = 1'b1;
        check("waddr", {58'd0, wr.wAddr}, 64'(exp_addr));
        check("wdin", {32'd0, wr.wDin}, {32'd0, term});
        check("ovf", {63'd0, ovf}, {63'd0, movf});
        case (exp_addr)
          2:  check("vec_a2", {32'd0, wr.wDin}, 64'd4);
          3:  check("vec_a3", {32'd0, wr.wDin}, 64'd6);
          4:  check("vec_a4", {32'd0, wr.wDin}, 64'd10);
          5:  check("vec_a5", {32'd0, wr.wDin}, 64'd16);
          6:  check("vec_a6", {32'd0, wr.wDin}, 64'd26);
          45: begin
            check("vec_a45", {32'd0, wr.wDin}, 64'd3672623806);
            check("ovf_a45", {63'd0, ovf}, 64'd0);
          end
          46: begin
`ifdef FIB_SAT_EN
            check("vec_a46", {32'd0, wr.wDin}, 64'hFFFF_FFFF);
`else
            check("vec_a46", {32'd0, wr.wDin}, 64'd1647462850);
`endif
            check("ovf_a46", {63'd0, ovf}, 64'd1);
          end
`ifdef FIB_SAT_EN
          63: check("vec_a63", {32'd0, wr.wDin}, 64'hFFFF_FFFF);
`endif
          default: ;
        endcase
        ma = mb; mb = term; exp_addr++; writes++;
        if (int'(wr.wAddr) == stall_at && stall_n > 0) begin
          stall = 1'b1;
          stall_left = stall_n;
        end
        if (int'(wr.wAddr) == abort_at) begin
          rst_n = 1'b0;
          #1;
          check("abort_wena", {63'd0, wr.wEna}, 64'd0);
          check("abort_waddr", {58'd0, wr.wAddr}, 64'd0);
          check("abort_wdin", {32'd0, wr.wDin}, 64'd0);
          check("abort_busy", {63'd0, busy}, 64'd0);
          check("abort_ovf", {63'd0, ovf}, 64'd0);
          rst_n = 1'b1;
          aborted = 1;
        end
      end
      if (done) begin
        seen = 1;
        done_cyc = c;
      end
    end
    if (!aborted) begin
      check("done_seen", {63'd0, seen}, 64'd1);
      check("done_cycle", 64'(done_cyc), 64'(63 + stall_n));
      check("write_count", 64'(writes), 64'd62);
      check("busy_at_done", {63'd0, busy}, 64'd0);
      check("ovf_end", {63'd0, ovf}, 64'd1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    start = 1'b0;
    stall = 1'b0;

    // Reset asserted mid-cycle must clear outputs without a clock edge.
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wena", {63'd0, wr.wEna}, 64'd0);
    check("rst_waddr", {58'd0, wr.wAddr}, 64'd0);
    check("rst_wdin", {32'd0, wr.wDin}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_wena", {63'd0, wr.wEna}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);

    // Basic run.
    start = 1'b1;
    step();
    start = 1'b0;
    check("e0_busy", {63'd0, busy}, 64'd1);
    check("e0_wena", {63'd0, wr.wEna}, 64'd0);
    run(-1, 0, -1, -1);

    // Start while done is high is accepted and clears ovf.
    start = 1'b1;
    step();
    start = 1'b0;
    check("done_pulse_end", {63'd0, done}, 64'd0);
    check("restart_busy", {63'd0, busy}, 64'd1);
    check("restart_ovf_clr", {63'd0, ovf}, 64'd0);

    // Stall for three cycles after the write to address 5.
    run(5, 3, -1, -1);
    step();
    check("post_done", {63'd0, done}, 64'd0);
    check("post_busy", {63'd0, busy}, 64'd0);
    check("post_wena", {63'd0, wr.wEna}, 64'd0);

    // Start during RUN is ignored; reset at address 20 aborts.
    start = 1'b1;
    step();
    start = 1'b0;
    run(-1, 0, 10, 20);
    step();
    check("abort_idle_busy", {63'd0, busy}, 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rerun_wena", {63'd0, wr.wEna}, 64'd1);
    check("rerun_waddr", {58'd0, wr.wAddr}, 64'd2);
    check("rerun_wdin", {32'd0, wr.wDin}, 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
